// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, parity modes and bit-timing helpers.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  // Clocks per bit (integer division, fraction dropped).
  function automatic int calc_cycle(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Mid-bit sample point within a bit period.
  function automatic int calc_half(input int cycle);
    return cycle / 2;
  endfunction

  // 2-of-3 majority vote.
  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // True when the received parity bit matches the data for the given mode.
  function automatic logic parity_ok(input logic data_xor, input logic par_bit, input int mode);
    logic ok;
    case (mode)
      PARITY_ODD:  ok = (data_xor ^ par_bit) == 1'b1;
      PARITY_EVEN: ok = (data_xor ^ par_bit) == 1'b0;
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read port; head reads as 0 when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign empty     = (count_r == (AW+1)'(0));
  assign full      = (count_r == (AW+1)'(DEPTH));
  assign pop_ok_s  = pop & ~empty;
  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign push_ok_s = push & (~full | pop_ok_s);
  assign rdata     = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Storage array write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy count (pointers wrap naturally since DEPTH is a power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-voted sampling, parity/stop checking and a receive FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] data,
  output logic                 available,
  input  logic                 read,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 clear_err
);

  localparam int CYCLE_C = calc_cycle(CLK_FREQ, BAUD_RATE);
  localparam int HALF_C  = calc_half(CYCLE_C);
  localparam int CNT_W   = $clog2(CYCLE_C + 1);

  rx_state_e            state_r, state_n;
  logic [1:0]           sync_r;
  logic [1:0]           sync_vld_r;
  logic                 armed_r;
  logic [CNT_W-1:0]     cnt_r, cnt_n;
  logic [3:0]           bit_cnt_r, bit_cnt_n;
  logic [DATA_BITS-1:0] shift_r, shift_n;
  logic [1:0]           smp_r;
  logic                 par_bad_r, par_bad_n;
  logic                 stop_bad_r, stop_bad_n;
  logic                 push_r;
  logic                 parity_err_r, frame_err_r, overrun_r;
  logic                 rx_s, vote_tick_s, bit_end_s, bit_val_s, stop_bad_all_s;
  logic                 push_s, perr_set_s, ferr_set_s, ovr_set_s;
  logic                 full_s, empty_s;

  assign rx_s        = sync_r[1];
  assign vote_tick_s = (cnt_r == CNT_W'(HALF_C + 1));
  assign bit_end_s   = (cnt_r == CNT_W'(CYCLE_C - 1));
  assign bit_val_s   = vote3(smp_r[0], smp_r[1], rx_s);

  // Two-flop synchroniser on the serial line, plus a fill marker so preset values are never trusted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r     <= 2'b11;
      sync_vld_r <= 2'b00;
    end else begin
      sync_r     <= {sync_r[0], rx_pin};
      sync_vld_r <= {sync_vld_r[0], 1'b1};
    end
  end

  // Arm start detection only after a genuine high line has been seen since reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) armed_r <= 1'b0;
    else     armed_r <= armed_r | (sync_vld_r[1] & rx_s);
  end

  // Capture the first two of the three voting samples around mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_r <= 2'b11;
    end else begin
      if (cnt_r == CNT_W'(HALF_C - 1)) smp_r[0] <= rx_s;
      if (cnt_r == CNT_W'(HALF_C))     smp_r[1] <= rx_s;
    end
  end

  // Next-state, datapath and event strobes for the receive FSM.
  always_comb begin
    state_n        = state_r;
    cnt_n          = cnt_r + CNT_W'(1);
    bit_cnt_n      = bit_cnt_r;
    shift_n        = shift_r;
    par_bad_n      = par_bad_r;
    stop_bad_n     = stop_bad_r;
    stop_bad_all_s = stop_bad_r | ~bit_val_s;
    push_s         = 1'b0;
    perr_set_s     = 1'b0;
    ferr_set_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_n      = {CNT_W{1'b0}};
        bit_cnt_n  = 4'd0;
        par_bad_n  = 1'b0;
        stop_bad_n = 1'b0;
        if (armed_r && !rx_s) state_n = ST_START;
        else                  state_n = ST_IDLE;
      end
      ST_START: begin
        if (vote_tick_s && bit_val_s) begin
          state_n = ST_IDLE;
          cnt_n   = {CNT_W{1'b0}};
        end else if (bit_end_s) begin
          state_n = ST_DATA;
          cnt_n   = {CNT_W{1'b0}};
        end else begin
          state_n = ST_START;
        end
      end
      ST_DATA: begin
        if (vote_tick_s) shift_n = {bit_val_s, shift_r[DATA_BITS-1:1]};
        else             shift_n = shift_r;
        if (bit_end_s) begin
          cnt_n = {CNT_W{1'b0}};
          if (bit_cnt_r == 4'(DATA_BITS - 1)) begin
            bit_cnt_n = 4'd0;
            state_n   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_n = bit_cnt_r + 4'd1;
            state_n   = ST_DATA;
          end
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (vote_tick_s) par_bad_n = ~parity_ok(^shift_r, bit_val_s, PARITY);
        else             par_bad_n = par_bad_r;
        if (bit_end_s) begin
          cnt_n   = {CNT_W{1'b0}};
          state_n = ST_STOP;
        end else begin
          state_n = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (vote_tick_s && (bit_cnt_r == 4'(STOP_BITS - 1))) begin
          // Final stop-bit vote: the frame verdict is decided here.
          cnt_n      = {CNT_W{1'b0}};
          bit_cnt_n  = 4'd0;
          push_s     = ~stop_bad_all_s & ~par_bad_r;
          perr_set_s = par_bad_r;
          ferr_set_s = stop_bad_all_s;
          if (stop_bad_all_s) state_n = ST_WAIT_IDLE;
          else                state_n = ST_IDLE;
        end else if (vote_tick_s) begin
          stop_bad_n = stop_bad_all_s;
        end else if (bit_end_s) begin
          cnt_n     = {CNT_W{1'b0}};
          bit_cnt_n = bit_cnt_r + 4'd1;
        end else begin
          state_n = ST_STOP;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_n = {CNT_W{1'b0}};
        if (rx_s) state_n = ST_IDLE;
        else      state_n = ST_WAIT_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = {CNT_W{1'b0}};
      end
    endcase
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      bit_cnt_r  <= 4'd0;
      shift_r    <= {DATA_BITS{1'b0}};
      par_bad_r  <= 1'b0;
      stop_bad_r <= 1'b0;
      push_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      bit_cnt_r  <= bit_cnt_n;
      shift_r    <= shift_n;
      par_bad_r  <= par_bad_n;
      stop_bad_r <= stop_bad_n;
      push_r     <= push_s;
    end
  end

  // A push into a full FIFO is lost unless a pop happens in the same cycle.
  assign ovr_set_s = push_r & full_s & ~(read & ~empty_s);

  // Sticky error flags; a set in the same cycle as clear_err wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      parity_err_r <= perr_set_s | (parity_err_r & ~clear_err);
      frame_err_r  <= ferr_set_s | (frame_err_r & ~clear_err);
      overrun_r    <= ovr_set_s  | (overrun_r & ~clear_err);
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_r),
    .wdata (shift_r),
    .pop   (read),
    .rdata (data),
    .full  (full_s),
    .empty (empty_s)
  );

  assign available  = ~empty_s;
  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: 8N1 instance (a) and even-parity instance (b) at 27 MHz / 115200.
module tb_uart_rx_fifo;

  localparam int BIT_T = 27_000_000 / 115200;  // 234 clocks per bit

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, read_a, clr_a;
  logic       rx_b, read_b, clr_b;
  logic [7:0] data_a, data_b;
  logic       avail_a, perr_a, ferr_a, ovr_a;
  logic       avail_b, perr_b, ferr_b, ovr_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo dut_a (
    .clk(clk), .rst(rst), .rx_pin(rx_a), .data(data_a), .available(avail_a),
    .read(read_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a),
    .clear_err(clr_a)
  );

  uart_rx_fifo #(.PARITY(2)) dut_b (
    .clk(clk), .rst(rst), .rx_pin(rx_b), .data(data_b), .available(avail_b),
    .read(read_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b),
    .clear_err(clr_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic send_bit(input bit sel, input logic v);
    drive_rx(sel, v);
    repeat (BIT_T) tick();
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b, input bit use_par,
                            input logic par_bit, input logic stop_v);
    send_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, b[i]);
    if (use_par) send_bit(sel, par_bit);
    send_bit(sel, stop_v);
    drive_rx(sel, 1'b1);
  endtask

  task automatic pop(input bit sel);
    if (sel) read_b = 1'b1;
    else     read_a = 1'b1;
    tick();
    read_a = 1'b0;
    read_b = 1'b0;
  endtask

  task automatic clear(input bit sel);
    if (sel) clr_b = 1'b1;
    else     clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    clr_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    read_a = 1'b0; read_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    repeat (4) tick();
    check("rst_avail", avail_a, 1'b0);
    check("rst_data", data_a, 8'h00);
    check("rst_perr", perr_a, 1'b0);
    check("rst_ferr", ferr_a, 1'b0);
    check("rst_ovr", ovr_a, 1'b0);
    rst = 1'b0;
    repeat (20) tick();

    // 8N1 0x41: word present by end of frame (10 bit times)
    send_frame(1'b0, 8'h41, 1'b0, 1'b0, 1'b1);
    check("t41_avail", avail_a, 1'b1);
    check("t41_data", data_a, 8'h41);
    pop(1'b0);
    check("t41_avail_after_read", avail_a, 1'b0);
    check("t41_data_empty", data_a, 8'h00);

    // Even parity: 0x41 has two ones, so parity bit 1 is wrong
    send_frame(1'b1, 8'h41, 1'b1, 1'b1, 1'b1);
    check("par_err_set", perr_b, 1'b1);
    check("par_avail", avail_b, 1'b0);
    check("par_ferr", ferr_b, 1'b0);
    clear(1'b1);
    check("par_err_clear", perr_b, 1'b0);
    send_frame(1'b1, 8'h41, 1'b1, 1'b0, 1'b1);
    check("par_good_avail", avail_b, 1'b1);
    check("par_good_data", data_b, 8'h41);
    pop(1'b1);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    check("par_good2_data", data_b, 8'h07);
    check("par_good2_perr", perr_b, 1'b0);
    pop(1'b1);

    // Overrun: five bytes into a four-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
      repeat (5) tick();
    end
    check("ovr_set", ovr_a, 1'b1);
    check("ovr_head", data_a, 8'h01);
    repeat (10) tick();
    check("ovr_head_stable", data_a, 8'h01);
    for (int i = 1; i <= 4; i++) begin
      check("ovr_order", data_a, 32'(i));
      pop(1'b0);
    end
    check("ovr_drained", avail_a, 1'b0);
    clear(1'b0);
    check("ovr_clear", ovr_a, 1'b0);

    // Glitch of a quarter bit on an idle line
    rx_a = 1'b0;
    repeat (BIT_T / 4) tick();
    rx_a = 1'b1;
    repeat (2 * BIT_T) tick();
    check("glitch_avail", avail_a, 1'b0);
    check("glitch_perr", perr_a, 1'b0);
    check("glitch_ferr", ferr_a, 1'b0);
    check("glitch_ovr", ovr_a, 1'b0);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    check("glitch_next_data", data_a, 8'h5A);
    pop(1'b0);

    // Framing error then a line held low, then a clean 0xAA
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    rx_a = 1'b0;
    repeat (2 * BIT_T) tick();
    rx_a = 1'b1;
    repeat (BIT_T) tick();
    check("ferr_no_word", avail_a, 1'b0);
    send_frame(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1);
    check("ferr_set", ferr_a, 1'b1);
    check("ferr_perr", perr_a, 1'b0);
    check("ferr_aa_data", data_a, 8'hAA);
    pop(1'b0);
    check("ferr_only_aa", avail_a, 1'b0);

    // Reset in the middle of a 0xF0 frame, released while the line is low
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    repeat (100) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("mid_rst_avail", avail_a, 1'b0);
    check("mid_rst_data", data_a, 8'h00);
    check("mid_rst_ferr", ferr_a, 1'b0);
    check("mid_rst_perr", perr_a, 1'b0);
    check("mid_rst_ovr", ovr_a, 1'b0);
    repeat (BIT_T) tick();
    rst = 1'b0;
    repeat (131 + BIT_T) tick();
    rx_a = 1'b1;
    repeat (5 * BIT_T) tick();
    check("post_rst_ignored", avail_a, 1'b0);
    check("post_rst_ferr", ferr_a, 1'b0);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    check("post_rst_avail", avail_a, 1'b1);
    check("post_rst_data", data_a, 8'h3C);
    check("post_rst_flags", {perr_a, ferr_a, ovr_a}, 3'b000);
    pop(1'b0);
    check("post_rst_empty", avail_a, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 27_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal 5..9, data bits per frame.
REQ-004 SHALL have parameter PARITY, default 0, encoding 0 none / 1 odd / 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, power of two, 2..64.
REQ-007 SHALL have port clk, input, 1, sole clock; one clock, all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-009 SHALL have port rx_pin, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL have port data, output, DATA_BITS, FIFO head word (first-word-fall-through).
REQ-011 SHALL have port available, output, 1, high while the FIFO is not empty.
REQ-012 SHALL have port read, input, 1, one-cycle pop strobe.
REQ-013 SHALL have port parity_err, output, 1, sticky parity-error flag.
REQ-014 SHALL have port frame_err, output, 1, sticky framing-error flag.
REQ-015 SHALL have port overrun, output, 1, sticky FIFO-full drop flag.
REQ-016 SHALL have port clear_err, input, 1, one-cycle strobe that clears all three sticky flags.

Function
REQ-017 SHALL pass rx_pin through a 2-FF synchroniser (preset to 1) before any use.
REQ-018 SHALL use CYCLE = CLK_FREQ/BAUD_RATE (integer division) clocks per bit, sampling at HALF = CYCLE/2.
REQ-019 SHALL form each bit value by 2-of-3 majority of the samples at HALF-1, HALF and HALF+1.
REQ-020 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-021 SHALL leave IDLE for START on the first synchronised low sample.
REQ-022 SHALL return from START to IDLE without side effects if the start bit votes high (glitch rejection).
REQ-023 SHALL shift DATA_BITS bits LSB first in DATA.
REQ-024 SHALL enter PARITY only when PARITY != 0, and skip it otherwise.
REQ-025 SHALL check every stop bit in STOP (STOP_BITS of them).
REQ-026 SHALL go from STOP to IDLE when every stop bit is high.
REQ-027 SHALL go from STOP to WAIT_IDLE when any stop bit is low, and stay there until the synchronised line is high.
REQ-028 SHALL push the word when the frame is good: the push occurs in the cycle after the last stop-bit vote, and available rises the following cycle.
REQ-029 SHALL discard the word and set parity_err on a parity mismatch.
REQ-030 SHALL discard the word and set frame_err on a low stop bit; when both errors occur, both flags are set.
REQ-031 SHALL drop the new word and set overrun when a push finds the FIFO full; FIFO contents are unchanged.
REQ-032 SHALL pop the head on read when available; read while empty is ignored.
REQ-033 SHALL, on simultaneous push and pop when the FIFO is full, perform both with no overrun.
REQ-034 SHALL, on simultaneous push and pop when the FIFO is empty, make the pushed word the head.
REQ-035 SHALL let a flag-set in the same cycle as clear_err win (flag ends at 1).
REQ-036 SHALL keep data stable while available is high and no read occurs.
REQ-037 SHALL drive data to 0 when the FIFO is empty.

Reset
REQ-038 SHALL, on rst assertion (any time, including mid-frame), immediately put the FSM in IDLE, empty the FIFO and clear counters, shift register and synchroniser (to 1).
REQ-039 SHALL drive available=0, data=0, parity_err=0, frame_err=0, overrun=0 while rst is high.
REQ-040 SHALL ignore a frame in progress at reset release until the line next goes high and a new start bit is seen.

Structure
REQ-041 SHALL put FSM state encoding, PARITY_NONE/ODD/EVEN constants and the CYCLE/HALF helper functions in shared package uart_pkg.
REQ-042 SHALL implement the FIFO as sub-module sync_fifo (params WIDTH, DEPTH; push/pop/full/empty), reusable by a future TX FIFO.

Verification
REQ-043 SHALL cover: 8N1, byte 0x41 at 27 MHz/115200 -> available=1 within 10.5 bit times, data=0x41; read -> available=0 next cycle.
REQ-044 SHALL cover: PARITY=2, 0x41 sent with parity bit 1 -> parity_err=1, available stays 0; clear_err -> parity_err=0.
REQ-045 SHALL cover: FIFO_DEPTH=4, bytes 0x01..0x05 without reads -> overrun=1; four reads return 0x01,0x02,0x03,0x04 in order.
REQ-046 SHALL cover: a low pulse of CYCLE/4 clocks on an idle line -> no push, no flags, FSM back in IDLE.
REQ-047 SHALL cover: 0x55 with stop bit low, then line held low for 2 bit times, then 0xAA sent normally -> frame_err=1, only 0xAA received.
REQ-048 SHALL cover: rst asserted mid-DATA of one byte -> all outputs 0; the following clean 0x3C frame is received correctly.
